// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared funct3 codes, FSM encoding and limits for the data-memory responder
package rv32_mem_pkg;

    // RV32I load/store width selectors (funct3)
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Largest supported number of wait states (fits the 4-bit counter)
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - extracts and sign/zero-extends byte, half or word load data
module load_formatter
    import rv32_mem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  byte_lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/half, then extend according to funct3
    always_comb begin
        sel_byte  = raw_word[7:0];
        sel_half  = byte_lane[1] ? raw_word[31:16] : raw_word[15:0];
        load_data = 32'd0;

        case (byte_lane)
            2'd0:    sel_byte = raw_word[7:0];
            2'd1:    sel_byte = raw_word[15:8];
            2'd2:    sel_byte = raw_word[23:16];
            default: sel_byte = raw_word[31:24];
        endcase

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = raw_word;
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory responder with wait states and fault detection
module data_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam int          WS_LOAD_I  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WS_LOAD    = 4'(WS_LOAD_I);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
        $error("WAIT_STATES must be in 0..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of 2");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        enter_resp;

    logic [31:0] mem_q [DEPTH_WORDS];

    // With zero wait states the commit edge is also the accept edge, so the
    // request being committed comes straight from the inputs while in IDLE.
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [2:0]    cur_f3;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_idx;
    logic [1:0]    cur_lane;

    logic          out_of_range;
    logic          misaligned;
    logic          illegal_f3;
    logic          acc_err;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;
    logic [31:0]   raw_word;
    logic [31:0]   fmt_data;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;

    // Select the request being served: live inputs in IDLE, latched copy otherwise
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_f3    = f3_q;
        cur_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_f3    = req_funct3;
            cur_wdata = req_wdata;
        end
        cur_idx  = cur_addr[AW+1:2];
        cur_lane = cur_addr[1:0];
    end

    // Next-state logic: accept in IDLE, count down in WAIT, pulse in RESP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        f3_d       = f3_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fault classification of the request being committed
    always_comb begin
        out_of_range = ({1'b0, cur_addr} >= ADDR_LIMIT);
        misaligned   = 1'b0;
        case (cur_f3)
            F3_H, F3_HU: misaligned = cur_addr[0];
            F3_W:        misaligned = (cur_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        if (cur_we) begin
            illegal_f3 = (cur_f3 > F3_W);
        end else begin
            illegal_f3 = (cur_f3 == 3'd3) || (cur_f3 == 3'd6) || (cur_f3 == 3'd7);
        end
        acc_err = out_of_range | misaligned | illegal_f3;
    end

    // Byte-enable and lane-replicated write data for stores
    always_comb begin
        mem_be = 4'b0000;
        mem_wd = cur_wdata;
        case (cur_f3)
            F3_B: begin
                mem_be = 4'b0001 << cur_lane;
                mem_wd = {4{cur_wdata[7:0]}};
            end
            F3_H: begin
                mem_be = cur_lane[1] ? 4'b1100 : 4'b0011;
                mem_wd = {2{cur_wdata[15:0]}};
            end
            F3_W: begin
                mem_be = 4'b1111;
                mem_wd = cur_wdata;
            end
            default: begin
                mem_be = 4'b0000;
                mem_wd = cur_wdata;
            end
        endcase
        mem_we = enter_resp & cur_we & ~acc_err;
    end

    assign raw_word = mem_q[cur_idx];

    load_formatter u_load_formatter (
        .raw_word  (raw_word),
        .byte_lane (cur_lane),
        .funct3    (cur_f3),
        .load_data (fmt_data)
    );

    // Response registers update only on the edge that enters RESP
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || cur_we) ? 32'd0 : fmt_data;
        end
    end

    // Control and response state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: byte-lane writes, contents not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[cur_idx][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
    import rv32_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_we, req_ready, rsp_valid, rsp_error;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    logic        z_req_valid, z_req_we, z_req_ready, z_rsp_valid, z_rsp_error;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [2:0]  z_req_funct3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_z (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_we     (z_req_we),
        .req_addr   (z_req_addr),
        .req_funct3 (z_req_funct3),
        .req_wdata  (z_req_wdata),
        .rsp_valid  (z_rsp_valid),
        .rsp_rdata  (z_rsp_rdata),
        .rsp_error  (z_rsp_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on the WAIT_STATES=1 instance and wait for its response
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int wdog;
        wdog = 0;
        @(negedge clk);
        while (!req_ready && wdog < 20) begin
            @(negedge clk);
            wdog++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        lat = 0;
        rd  = 32'hBAD0_BAD0;
        er  = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                er  = rsp_error;
                break;
            end
        end
    endtask

    // Request plus checks of data, error flag and latency (WAIT_STATES+1 sampled cycles)
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(we, f3, addr, wd, rd, er, lat);
        check({tag, "/rdata"}, rd, exp_rd);
        check({tag, "/error"}, 32'(er), 32'(exp_er));
        check({tag, "/latency"}, 32'(lat), 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_funct3   = 3'd0;
        req_wdata    = 32'd0;
        z_req_valid  = 1'b0;
        z_req_we     = 1'b0;
        z_req_addr   = 32'd0;
        z_req_funct3 = 3'd0;
        z_req_wdata  = 32'd0;

        repeat (3) @(negedge clk);
        check("reset/req_ready", 32'(req_ready), 32'd1);
        check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'd0);
        check("reset/rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b1;

        // Word store then load, then sub-word loads with sign/zero extension
        access("sw_10",  1'b1, F3_W,  32'h10, 32'h8000_00FF, 32'h0000_0000, 1'b0);
        access("lw_10",  1'b0, F3_W,  32'h10, 32'h0,         32'h8000_00FF, 1'b0);
        repeat (2) @(negedge clk);
        check("lw_10/hold", rsp_rdata, 32'h8000_00FF);
        access("lb_13",  1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
        access("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
        access("lh_10",  1'b0, F3_H,  32'h10, 32'h0, 32'h0000_00FF, 1'b0);
        access("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_8000, 1'b0);
        access("lh_12",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_8000, 1'b0);

        // Partial stores leave the other lanes intact and ignore upper wdata
        access("sb_11",  1'b1, F3_B,  32'h11, 32'h1234_56AB, 32'h0, 1'b0);
        access("lw_sb",  1'b0, F3_W,  32'h10, 32'h0, 32'h8000_ABFF, 1'b0);
        access("sh_12",  1'b1, F3_H,  32'h12, 32'hFFFF_1234, 32'h0, 1'b0);
        access("lw_sh",  1'b0, F3_W,  32'h10, 32'h0, 32'h1234_ABFF, 1'b0);

        // Faults: misaligned, out of range, illegal width; none may write
        access("lw_12_mis",  1'b0, F3_W,  32'h12,   32'h0,         32'h0, 1'b1);
        access("sw_1002",    1'b1, F3_W,  32'h1002, 32'h5555_5555, 32'h0, 1'b1);
        access("sw_1000",    1'b1, F3_W,  32'h1000, 32'h5555_5555, 32'h0, 1'b1);
        access("lh_11_mis",  1'b0, F3_H,  32'h11,   32'h0,         32'h0, 1'b1);
        access("lhu_13_mis", 1'b0, F3_HU, 32'h13,   32'h0,         32'h0, 1'b1);
        access("ld_f3_3",    1'b0, 3'd3,  32'h10,   32'h0,         32'h0, 1'b1);
        access("ld_f3_6",    1'b0, 3'd6,  32'h10,   32'h0,         32'h0, 1'b1);
        access("st_f3_4",    1'b1, 3'd4,  32'h10,   32'hEEEE_EEEE, 32'h0, 1'b1);
        access("sh_11_mis",  1'b1, F3_H,  32'h11,   32'hEEEE_EEEE, 32'h0, 1'b1);
        access("lw_10_kept", 1'b0, F3_W,  32'h10,   32'h0, 32'h1234_ABFF, 1'b0);

        // Top word of storage is still in range
        access("sw_ffc",  1'b1, F3_W,  32'hFFC, 32'h5A00_0000, 32'h0, 1'b0);
        access("lbu_fff", 1'b0, F3_BU, 32'hFFF, 32'h0, 32'h0000_005A, 1'b0);
        access("lw_ffc",  1'b0, F3_W,  32'hFFC, 32'h0, 32'h5A00_0000, 1'b0);

        // Zero wait states: store, then a held load stream at full rate
        @(negedge clk);
        z_req_valid  = 1'b1;
        z_req_we     = 1'b1;
        z_req_funct3 = F3_W;
        z_req_addr   = 32'h0;
        z_req_wdata  = 32'hCAFE_F00D;
        @(negedge clk);
        check("z_sw/rsp_valid", 32'(z_rsp_valid), 32'd1);
        check("z_sw/rsp_error", 32'(z_rsp_error), 32'd0);
        z_req_valid = 1'b0;
        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_we    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("z_stream/req_ready", 32'(z_req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("z_stream/rsp_valid", 32'(z_rsp_valid), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 1) begin
                check("z_stream/rsp_rdata", z_rsp_rdata, 32'hCAFE_F00D);
            end
            @(negedge clk);
        end
        z_req_valid = 1'b0;

        // Reset while a store sits in WAIT: dropped, no write, no response
        access("sw_20_zero", 1'b1, F3_W, 32'h20, 32'h0, 32'h0, 1'b0);
        access("lw_10_pre",  1'b0, F3_W, 32'h10, 32'h0, 32'h1234_ABFF, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h20;
        req_wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid/in_wait_ready", 32'(req_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_mid/req_ready", 32'(req_ready), 32'd1);
        check("rst_mid/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid/rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_mid/no_response", 32'(seen), 32'd0);
        access("lw_20_after", 1'b0, F3_W, 32'h20, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
